// File: rtl/mips_burst_lsu.sv
// Multi-word load/store sequencer: splits one N-word request into N single-word SRAM accesses.
// Latency: word 0 is combinational in the request cycle, then one word per cycle; stall holds the PC until the last word.
// Backpressure: none accepted. req_valid is ignored while busy. Optional MIPS_LSU_STATS_EN adds word and stall counters.
module mips_burst_lsu #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [CNT_W-1:0]  req_words,
    input  logic [31:0]       req_addr,
    input  logic [4:0]        req_rt,
    input  logic [DATA_W-1:0] st_data,
    output logic [4:0]        rf_rd_idx,
    output logic              rf_we,
    output logic [4:0]        rf_wr_idx,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              stall,
    output logic              busy,
    output logic              err,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Data2Mem,
    input  logic [DATA_W-1:0] ReadDataMem,
    output logic [31:0]       stat_words,
    output logic [31:0]       stat_stalls
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   words_q;
    logic [ADDR_W-1:0]  base_q;
    logic [4:0]         rt_q;
    logic               write_q;

    logic [CNT_W-1:0]   w_eff;
    logic               req_take;
    logic               req_act;
    logic               last_word;
    logic [ADDR_W-1:0]  req_base;
    logic               act;
    logic               act_wr;
    logic [4:0]         act_idx;
    logic [ADDR_W-1:0]  act_addr;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Oversize requests are clamped rather than dropped; err flags it instead.
    assign w_eff     = (req_words > MAX_CNT) ? MAX_CNT : req_words;
    assign req_take  = (state_q == IDLE) && req_valid;
    assign req_act   = req_take && (w_eff != '0);
    assign req_base  = req_addr[ADDR_W+1:2];
    assign last_word = (cnt_q == (words_q - CNT_W'(1)));

    always_comb begin
        act      = 1'b0;
        act_wr   = 1'b0;
        act_idx  = '0;
        act_addr = '0;
        stall    = 1'b0;
        busy     = 1'b0;
        err      = 1'b0;
        if (rst_n) begin
            if (state_q == BURST) begin
                act      = 1'b1;
                act_wr   = write_q;
                act_addr = base_q + ADDR_W'(cnt_q);
                act_idx  = rt_q + 5'(cnt_q);
                stall    = !last_word;
                busy     = 1'b1;
            end else if (req_act) begin
                act      = 1'b1;
                act_wr   = req_write;
                act_addr = req_base;
                act_idx  = req_rt;
                stall    = (w_eff > CNT_W'(1));
            end
            err = req_take && ((req_words > MAX_CNT) ||
                               ((req_words != '0) && (req_addr[1:0] != 2'b00)));
        end
    end

    always_comb begin
        CEN        = 1'b1;
        WEN        = 1'b1;
        OEN        = 1'b1;
        A          = '0;
        Data2Mem   = '0;
        rf_we      = 1'b0;
        rf_wr_idx  = '0;
        rf_wr_data = '0;
        rf_rd_idx  = '0;
        if (act) begin
            CEN = 1'b0;
            A   = act_addr;
            if (act_wr) begin
                WEN       = 1'b0;
                rf_rd_idx = act_idx;
                Data2Mem  = st_data;
            end else begin
                OEN        = 1'b0;
                rf_we      = 1'b1;
                rf_wr_idx  = act_idx;
                rf_wr_data = ReadDataMem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            words_q <= '0;
            base_q  <= '0;
            rt_q    <= '0;
            write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_act && (w_eff > CNT_W'(1))) begin
                        state_q <= BURST;
                        cnt_q   <= CNT_W'(1);
                        words_q <= w_eff;
                        base_q  <= req_base;
                        rt_q    <= req_rt;
                        write_q <= req_write;
                    end
                end
                BURST: begin
                    if (last_word) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MIPS_LSU_STATS_EN
    logic [31:0] stat_words_q;
    logic [31:0] stat_stalls_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (!CEN)
                stat_words_q <= stat_words_q + 32'd1;
            if (stall)
                stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_stalls = stat_stalls_q;
`else
    assign stat_words  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_mips_burst_lsu.sv
// Scoreboard bench for mips_burst_lsu: expected per-cycle outputs are queued when a request is driven.
module tb_mips_burst_lsu;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int MAXW   = 4;
    localparam int CNT_W  = $clog2(MAXW + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic [CNT_W-1:0]  req_words = '0;
    logic [31:0]       req_addr = '0;
    logic [4:0]        req_rt = '0;
    logic [DATA_W-1:0] st_data = '0;
    logic [DATA_W-1:0] ReadDataMem = '0;
    logic [4:0]        rf_rd_idx;
    logic              rf_we;
    logic [4:0]        rf_wr_idx;
    logic [DATA_W-1:0] rf_wr_data;
    logic              stall, busy, err, CEN, WEN, OEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] Data2Mem;
    logic [31:0]       stat_words, stat_stalls;

    always #5 clk = ~clk;

    mips_burst_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_words(req_words), .req_addr(req_addr), .req_rt(req_rt), .st_data(st_data),
        .rf_rd_idx(rf_rd_idx), .rf_we(rf_we), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .stall(stall), .busy(busy), .err(err), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
        .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem),
        .stat_words(stat_words), .stat_stalls(stat_stalls)
    );

    typedef struct {
        logic        cen, wen, oen, we, stl, bsy, er;
        logic [31:0] a, d2m, wr_idx, wr_data, rd_idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_words = 0;
    int   m_stalls = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.cen = 1; e.wen = 1; e.oen = 1; e.we = 0; e.stl = 0; e.bsy = 0; e.er = 0;
        e.a = 0; e.d2m = 0; e.wr_idx = 0; e.wr_data = 0; e.rd_idx = 0;
        return e;
    endfunction

    // One clock: drive at negedge, compare against the queue head before the posedge.
    task automatic run_cycle(input logic rst, input logic rv, input logic rw, input int words,
                             input logic [31:0] addr, input logic [4:0] rt, input logic [31:0] dat);
        exp_t e;
        @(negedge clk);
        rst_n = rst; req_valid = rv; req_write = rw; req_words = CNT_W'(words);
        req_addr = addr; req_rt = rt; st_data = dat; ReadDataMem = ~dat;
        #2;
`ifdef MIPS_LSU_STATS_EN
        check_eq("stat_words", stat_words, m_words);
        check_eq("stat_stalls", stat_stalls, m_stalls);
`else
        check_eq("stat_words_tied", stat_words, 0);
        check_eq("stat_stalls_tied", stat_stalls, 0);
`endif
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: empty queue, expected an entry");
            return;
        end
        e = exp_q.pop_front();
        check_eq("CEN", CEN, e.cen);
        check_eq("WEN", WEN, e.wen);
        check_eq("OEN", OEN, e.oen);
        check_eq("A", A, e.a);
        check_eq("Data2Mem", Data2Mem, e.d2m);
        check_eq("rf_we", rf_we, e.we);
        check_eq("rf_wr_idx", rf_wr_idx, e.wr_idx);
        check_eq("rf_wr_data", rf_wr_data, e.wr_data);
        check_eq("rf_rd_idx", rf_rd_idx, e.rd_idx);
        check_eq("stall", stall, e.stl);
        check_eq("busy", busy, e.bsy);
        check_eq("err", err, e.er);
        if (!rst) begin
            m_words = 0; m_stalls = 0;
        end else begin
            if (!e.cen) m_words++;
            if (e.stl) m_stalls++;
        end
    endtask

    function automatic exp_t word_exp(input logic rw, input int w, input int i,
                                      input logic [31:0] addr, input logic [4:0] rt,
                                      input logic [31:0] dat, input logic er);
        exp_t e = idle_exp();
        e.cen = 0;
        e.a   = ((addr >> 2) + i) % 128;
        e.stl = (i < w - 1);
        e.bsy = (i > 0);
        e.er  = er;
        if (rw) begin
            e.wen = 0; e.rd_idx = (rt + i) % 32; e.d2m = dat;
        end else begin
            e.oen = 0; e.we = 1; e.wr_idx = (rt + i) % 32; e.wr_data = ~dat;
        end
        return e;
    endfunction

    // Request held valid for the whole burst (core re-presents it), then one idle cycle.
    task automatic issue(input logic rw, input int words, input logic [31:0] addr,
                         input logic [4:0] rt, input logic [31:0] dbase);
        int w;
        logic er;
        w  = (words > MAXW) ? MAXW : words;
        er = (words > MAXW) || (words != 0 && addr[1:0] != 2'b00);
        if (w == 0) begin
            exp_q.push_back(idle_exp());
            run_cycle(1, 1, rw, words, addr, rt, dbase);
        end
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(word_exp(rw, w, i, addr, rt, dbase + i, (i == 0) ? er : 1'b0));
            run_cycle(1, 1, rw, words, addr, rt, dbase + i);
        end
        exp_q.push_back(idle_exp());
        run_cycle(1, 0, 0, 0, 32'h0, 5'd0, 32'h1234_5678);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(idle_exp());
            run_cycle(0, 1, 0, 2, 32'h40, 5'd3, 32'h5);
        end
        exp_q.push_back(idle_exp());
        run_cycle(1, 0, 0, 0, 32'h0, 5'd0, 32'h0);

        issue(0, 1, 32'h40,  5'd8,  ~32'hDEADBEEF);
        issue(0, 2, 32'h10,  5'd4,  32'h1000_0000);
        issue(1, 4, 32'h1F8, 5'd30, 32'h2000_0000);
        issue(0, 3, 32'h7C,  5'd31, 32'h3000_0000);

        // Reset lands on the second word of a four-word load.
        exp_q.push_back(word_exp(0, 4, 0, 32'h20, 5'd1, 32'h4000_0000, 1'b0));
        run_cycle(1, 1, 0, 4, 32'h20, 5'd1, 32'h4000_0000);
        exp_q.push_back(idle_exp());
        run_cycle(0, 1, 0, 4, 32'h20, 5'd1, 32'h4000_0001);
        exp_q.push_back(idle_exp());
        run_cycle(1, 0, 0, 0, 32'h0, 5'd0, 32'h0);

        issue(0, 0, 32'h44,  5'd2,  32'h5000_0000);
        issue(0, 6, 32'h100, 5'd2,  32'h6000_0000);
        issue(1, 1, 32'h13,  5'd9,  32'h7000_0000);
        issue(1, 2, 32'h0,   5'd0,  32'h8000_0000);

        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_burst_lsu.md
Name: mips_burst_lsu

Overview:
Parametrised multi-word load/store sequencer for the single-cycle MIPS core.
- Splits one N-word memory instruction (ldc1/sdc1 and wider) into N consecutive single-word SRAM accesses, one per cycle, over the existing CEN/WEN/OEN/A data-memory interface.
- Walks consecutive register indices and word addresses.
- Drives a stall to the core so the PC holds until the last word is transferred.
- Replaces the hard-wired two-word "double" toggle with a general FSM.

Parameters:
DATA_W, 32, data word width.
ADDR_W, 7, SRAM word-address width (A port).
MAX_WORDS, 4, maximum words per request (>=1).
CNT_W, $clog2(MAX_WORDS+1), width of the req_words field.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  memory instruction decoded this cycle
req_write  in  1  1 = store, 0 = load
req_words  in  CNT_W  number of words to move
req_addr  in  32  byte address from the ALU
req_rt  in  5  first register index
st_data  in  DATA_W  register-file read data for rf_rd_idx
rf_rd_idx  out  5  register index for store data
rf_we  out  1  register write enable (loads)
rf_wr_idx  out  5  register write index
rf_wr_data  out  DATA_W  register write data
stall  out  1  hold PC this cycle
busy  out  1  FSM in BURST
err  out  1  one-cycle pulse: misaligned address or oversize request
CEN  out  1  SRAM chip enable, active low
WEN  out  1  SRAM write enable, active low
OEN  out  1  SRAM output enable, active low
A  out  ADDR_W  SRAM word address
Data2Mem  out  DATA_W  SRAM write data
ReadDataMem  in  DATA_W  SRAM read data, valid in the same cycle
stat_words  out  32  words transferred (optional feature)
stat_stalls  out  32  stall cycles (optional feature)

Behaviour:
- Reset is synchronous, active-low, on clk. Any rst_n=0 cycle, including mid-burst, does the following:
  - State -> IDLE; count, latched address, latched rt and stats are cleared.
  - During that cycle, outputs are forced inactive: CEN=WEN=OEN=1, A=0, Data2Mem=0, rf_we=0, rf_wr_idx=0, rf_wr_data=0, rf_rd_idx=0, stall=0, busy=0, err=0.
- States: IDLE, BURST.
- Word 0 is performed combinationally in the request cycle, from the request inputs directly.
- IDLE with req_valid and effective word count W>=1:
  - Word 0: A = req_addr[ADDR_W+1:2], register index = req_rt.
  - W==1: stays in IDLE, stall=0.
  - W>1: latches base address, rt and W, sets cnt=1, moves to BURST, stall=1.
- BURST, word i=cnt:
  - A = base+i, mod 2^ADDR_W.
  - Register index = rt+i, mod 32.
  - stall=1 while i<W-1; stall=0 on the last word, so the PC advances at that edge.
  - Next state after the last word: IDLE.
- busy=1 exactly in BURST.
- req_valid is ignored in BURST, because the core re-presents the same instruction while stalled.
- Load cycle: CEN=0, OEN=0, WEN=1, rf_we=1, rf_wr_idx = current index, rf_wr_data = ReadDataMem.
- Store cycle: CEN=0, WEN=0, OEN=1, rf_rd_idx = current index, Data2Mem = st_data, rf_we=0.
- Inactive cycle (IDLE without a valid request): CEN=WEN=OEN=1, A=0, Data2Mem=0, rf_we=0, stall=0.
- req_words==0 is a no-op: no memory enable, no stall, no err.
- req_words>MAX_WORDS: W is clamped to MAX_WORDS, and err pulses in the request cycle.
- req_addr[1:0]!=0: the low bits are ignored, the access proceeds, and err pulses in the request cycle.

Optional Feature:
- Macro: MIPS_LSU_STATS_EN.
- Defined:
  - stat_words increments by 1 on every cycle with CEN=0.
  - stat_stalls increments on every cycle with stall=1.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Load, W=1, req_addr=0x40, rt=8, ReadDataMem=0xDEADBEEF -> same cycle: A=16, OEN=0, rf_we=1, rf_wr_idx=8, rf_wr_data=0xDEADBEEF, stall=0, busy=0 next cycle.
- Load, W=2, addr=0x10, rt=4 -> cycle0: A=4, idx=4, stall=1; cycle1: A=5, idx=5, stall=0, busy=1; cycle2: IDLE.
- Store, W=4, addr=0x1F8, rt=30, MAX_WORDS=4 -> A sequence 126, 127, 0, 1; rf_rd_idx sequence 30, 31, 0, 1; WEN=0 on all four; stall sequence 1, 1, 1, 0.
- rst_n=0 on the second word of a W=4 load -> that cycle CEN=1, stall=0; next cycle IDLE, busy=0; stat_words=0 with MIPS_LSU_STATS_EN.
- req_words=0 -> CEN=1, stall=0, err=0; req_words=6 with MAX_WORDS=4 -> err=1 for one cycle and exactly 4 accesses.
- Store, W=1, addr=0x13 -> err pulse, A=4, WEN=0.
